// File: rtl/riscv_pkg.sv
// Shared types for the RV32 execute stage: ALU opcodes, forwarding selects,
// divider operations and divider FSM states.
package riscv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  // Code 3 is reserved and falls back to the register file.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_t;

  // Taken straight from funct3: bit0 = unsigned, bit1 = remainder.
  typedef enum logic [2:0] {
    DIV_DIV  = 3'b100,
    DIV_DIVU = 3'b101,
    DIV_REM  = 3'b110,
    DIV_REMU = 3'b111
  } div_op_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_RUN  = 2'd1,
    DS_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU. Divide-by-zero and signed
// overflow are answered combinationally in IDLE without entering RUN.
module iterative_divider
  import riscv_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [2:0]              i_op,
  input  logic [P_DATA_WIDTH-1:0] i_dividend,
  input  logic [P_DATA_WIDTH-1:0] i_divisor,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [P_DATA_WIDTH-1:0] o_result
);

  localparam int DW = P_DATA_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] MIN_INT = {1'b1, {(DW-1){1'b0}}};

  div_state_t state, state_next;
  logic [CW-1:0] count;
  logic [DW-1:0] quo, rem, dvs;
  logic          neg_q, neg_r, sel_rem;

  logic          is_signed, want_rem, div_zero, overflow, special;
  logic          dividend_neg, divisor_neg;
  logic [DW-1:0] dividend_mag, divisor_mag, special_result;
  logic [DW:0]   rem_shift, rem_diff;
  logic [DW-1:0] quo_fixed, rem_fixed;

  assign is_signed      = ~i_op[0];
  assign want_rem       = i_op[1];
  assign div_zero       = (i_divisor == '0);
  assign overflow       = is_signed && (i_dividend == MIN_INT) && (i_divisor == '1);
  assign special        = div_zero | overflow;
  assign special_result = div_zero ? (want_rem ? i_dividend : '1)
                                   : (want_rem ? '0 : MIN_INT);

  assign dividend_neg = is_signed & i_dividend[DW-1];
  assign divisor_neg  = is_signed & i_divisor[DW-1];
  assign dividend_mag = dividend_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign divisor_mag  = divisor_neg  ? (~i_divisor + 1'b1)  : i_divisor;

  // One restoring step: bring down the next dividend bit and try to subtract.
  assign rem_shift = {rem, quo[DW-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs};

  assign quo_fixed = neg_q ? (~quo + 1'b1) : quo;
  assign rem_fixed = neg_r ? (~rem + 1'b1) : rem;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= DS_IDLE;
    else          state <= state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_result   = special_result;
    case (state)
      DS_IDLE: begin
        o_busy = i_start & ~special;
        o_done = i_start & special;
        if (i_start && !special) state_next = DS_RUN;
      end
      DS_RUN: begin
        o_busy = i_start;
        if (count == CW'(DW - 1)) state_next = DS_DONE;
      end
      DS_DONE: begin
        o_done     = 1'b1;
        o_result   = sel_rem ? rem_fixed : quo_fixed;
        state_next = DS_IDLE;
      end
      default: state_next = DS_IDLE;
    endcase
  end

  // Operand latch on start, then one quotient bit per RUN cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sel_rem <= 1'b0;
    end else if (state == DS_IDLE && i_start && !special) begin
      count   <= '0;
      quo     <= dividend_mag;
      rem     <= '0;
      dvs     <= divisor_mag;
      neg_q   <= dividend_neg ^ divisor_neg;
      neg_r   <= dividend_neg;
      sel_rem <= want_rem;
    end else if (state == DS_RUN) begin
      count <= count + 1'b1;
      if (!rem_diff[DW]) begin
        rem <= rem_diff[DW-1:0];
        quo <= {quo[DW-2:0], 1'b1};
      end else begin
        rem <= rem_shift[DW-1:0];
        quo <= {quo[DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch/jump resolution, iterative
// divider with front-end stall, and the EX/MEM pipeline register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_regwrite_e,
  input  logic [1:0]              i_resultsrc_e,
  input  logic                    i_memwrite_e,
  input  logic                    i_jump_e,
  input  logic                    i_jalr_e,
  input  logic                    i_branch_e,
  input  logic [2:0]              i_funct3_e,
  input  logic [3:0]              i_alucontrol_e,
  input  logic                    i_alusrc_e,
  input  logic                    i_div_e,
  input  logic [P_DATA_WIDTH-1:0] i_rs1_data_e,
  input  logic [P_DATA_WIDTH-1:0] i_rs2_data_e,
  input  logic [P_DATA_WIDTH-1:0] i_imm_ext_e,
  input  logic [P_ADDR_WIDTH-1:0] i_pc_e,
  input  logic [P_ADDR_WIDTH-1:0] i_pc4_e,
  input  logic [4:0]              i_rd_addr_e,
  input  logic [1:0]              i_forward_a_e,
  input  logic [1:0]              i_forward_b_e,
  input  logic [P_DATA_WIDTH-1:0] i_result_w,
  output logic                    o_stall_e,
  output logic                    o_pcsrc_e,
  output logic [P_ADDR_WIDTH-1:0] o_pc_target_e,
  output logic                    o_regwrite_m,
  output logic [1:0]              o_resultsrc_m,
  output logic                    o_memwrite_m,
  output logic [P_DATA_WIDTH-1:0] o_alu_result_m,
  output logic [P_DATA_WIDTH-1:0] o_write_data_m,
  output logic [4:0]              o_rd_addr_m,
  output logic [P_ADDR_WIDTH-1:0] o_pc4_m
);

  localparam int DW = P_DATA_WIDTH;
  localparam int AW = P_ADDR_WIDTH;

  logic [DW-1:0] src_a, fwd_b, src_b, alu_result, ex_result;
  logic [DW-1:0] div_result, target_full;
  logic          branch_cond, div_busy, div_done;

  // Operand forwarding; the reserved select falls back to the register file
  always_comb begin
    case (i_forward_a_e)
      FWD_WB:  src_a = i_result_w;
      FWD_MEM: src_a = o_alu_result_m;
      default: src_a = i_rs1_data_e;
    endcase
    case (i_forward_b_e)
      FWD_WB:  fwd_b = i_result_w;
      FWD_MEM: fwd_b = o_alu_result_m;
      default: fwd_b = i_rs2_data_e;
    endcase
  end

  assign src_b = i_alusrc_e ? i_imm_ext_e : fwd_b;

  // ALU; unknown opcodes produce zero
  always_comb begin
    alu_result = '0;
    case (i_alucontrol_e)
      ALU_ADD:   alu_result = src_a + src_b;
      ALU_SUB:   alu_result = src_a - src_b;
      ALU_AND:   alu_result = src_a & src_b;
      ALU_OR:    alu_result = src_a | src_b;
      ALU_XOR:   alu_result = src_a ^ src_b;
      ALU_SLT:   alu_result = {{(DW-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_result = {{(DW-1){1'b0}}, src_a < src_b};
      ALU_SLL:   alu_result = src_a << src_b[4:0];
      ALU_SRL:   alu_result = src_a >> src_b[4:0];
      ALU_SRA:   alu_result = $signed(src_a) >>> src_b[4:0];
      ALU_PASSB: alu_result = src_b;
      default:   alu_result = '0;
    endcase
  end

  // Branch condition on the forwarded register operands
  always_comb begin
    branch_cond = 1'b0;
    case (i_funct3_e)
      3'b000:  branch_cond = (src_a == fwd_b);
      3'b001:  branch_cond = (src_a != fwd_b);
      3'b100:  branch_cond = ($signed(src_a) <  $signed(fwd_b));
      3'b101:  branch_cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  branch_cond = (src_a <  fwd_b);
      3'b111:  branch_cond = (src_a >= fwd_b);
      default: branch_cond = 1'b0;
    endcase
  end

  assign target_full   = i_jalr_e ? ((src_a + i_imm_ext_e) & {{(DW-1){1'b1}}, 1'b0})
                                  : ({{(DW-AW){1'b0}}, i_pc_e} + i_imm_ext_e);
  assign o_pc_target_e = target_full[AW-1:0];
  assign o_pcsrc_e     = i_jump_e | (i_branch_e & branch_cond);

  iterative_divider #(
    .P_DATA_WIDTH(DW)
  ) u_divider (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_div_e),
    .i_op       (i_funct3_e),
    .i_dividend (src_a),
    .i_divisor  (fwd_b),
    .o_busy     (div_busy),
    .o_done     (div_done),
    .o_result   (div_result)
  );

  assign o_stall_e = div_busy;
  assign ex_result = (i_div_e && div_done) ? div_result : alu_result;

  // EX/MEM register; a bubble is inserted while the divider holds the stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || o_stall_e) begin
      o_regwrite_m   <= 1'b0;
      o_resultsrc_m  <= '0;
      o_memwrite_m   <= 1'b0;
      o_alu_result_m <= '0;
      o_write_data_m <= '0;
      o_rd_addr_m    <= '0;
      o_pc4_m        <= '0;
    end else begin
      o_regwrite_m   <= i_regwrite_e;
      o_resultsrc_m  <= i_resultsrc_e;
      o_memwrite_m   <= i_memwrite_e;
      o_alu_result_m <= ex_result;
      o_write_data_m <= fwd_b;
      o_rd_addr_m    <= i_rd_addr_e;
      o_pc4_m        <= i_pc4_e;
    end
  end

endmodule
